// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Run-control FSM for the 8-digit stopwatch/timer: start/stop/
//               pause sequencing, preset editing, count gating and alarm.
// Revision    : 1.0  initial release
// ============================================================================
module stopwatch_ctrl #(
  parameter int DIGITS         = 8,
  parameter int MIN_TENS_DIGIT = 5,
  parameter int ALARM_TICKS    = 30000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  enc_btn,
  input  logic                  enc_inc,
  input  logic                  enc_dec,
  input  logic                  tick,
  input  logic                  blink,
  input  logic                  at_zero,
  output logic [4*DIGITS-1:0]   preset,
  output logic                  load,
  output logic                  count_en,
  output logic                  count_up,
  output logic [2:0]            cursor,
  output logic [2:0]            state,
  output logic                  ready,
  output logic                  alarm
);

  localparam int c_ACNT_W = $clog2(ALARM_TICKS + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SET     = 3'd1,
    ST_RUN     = 3'd2,
    ST_PAUSE   = 3'd3,
    ST_EXPIRED = 3'd4
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [4*DIGITS-1:0]   r_preset, w_preset_nxt;
  logic [2:0]            r_cursor, w_cursor_nxt;
  logic                  r_load, w_load_nxt;
  logic                  r_load_d;
  logic                  r_count_en, w_count_en_nxt;
  logic                  r_count_up, w_count_up_nxt;
  logic                  r_ready, w_ready_nxt;
  logic [c_ACNT_W-1:0]   r_acnt, w_acnt_nxt;

  // Only the highest-priority pulse of a cycle is acted on
  logic w_stop, w_start, w_btn, w_inc, w_dec;
  assign w_stop  = stop;
  assign w_start = start & ~stop;
  assign w_btn   = enc_btn & ~stop & ~start;
  assign w_inc   = enc_inc & ~stop & ~start & ~enc_btn;
  assign w_dec   = enc_dec & ~stop & ~start & ~enc_btn & ~enc_inc;

  logic [3:0]          w_digit, w_lim, w_digit_inc, w_digit_dec;
  logic                w_preset_nz, w_expire, w_alarm_done;
  logic [c_ACNT_W-1:0] w_acnt_inc;

  assign w_digit     = r_preset[{r_cursor, 2'b00} +: 4];
  assign w_lim       = (r_cursor == 3'(MIN_TENS_DIGIT)) ? 4'd5 : 4'd9;
  assign w_digit_inc = (w_digit >= w_lim) ? 4'd0 : w_digit + 4'd1;
  assign w_digit_dec = (w_digit == 4'd0) ? w_lim : w_digit - 4'd1;
  assign w_preset_nz = |r_preset;
  // at_zero is stale while the chain is still absorbing the preload
  assign w_expire    = ~r_count_up & at_zero & ~r_load & ~r_load_d;
  assign w_acnt_inc  = r_acnt + c_ACNT_W'(1);
  assign w_alarm_done = tick & (w_acnt_inc == c_ACNT_W'(ALARM_TICKS));

  always_comb begin
    w_state_nxt    = r_state;
    w_preset_nxt   = r_preset;
    w_cursor_nxt   = r_cursor;
    w_load_nxt     = 1'b0;
    w_count_en_nxt = 1'b0;
    w_count_up_nxt = r_count_up;
    w_acnt_nxt     = r_acnt;
    case (r_state)
      ST_IDLE: begin
        if (mode) w_preset_nxt = '0;
        if (w_start) begin
          if (mode || w_preset_nz) begin
            w_load_nxt     = 1'b1;
            w_count_up_nxt = mode;
            w_state_nxt    = ST_RUN;
          end
        end else if (w_btn && !mode) begin
          w_state_nxt  = ST_SET;
          w_cursor_nxt = 3'd0;
        end
      end
      ST_SET: begin
        if (mode) begin
          w_state_nxt  = ST_IDLE;
          w_preset_nxt = '0;
          w_cursor_nxt = 3'd0;
        end else if (w_stop) begin
          w_state_nxt  = ST_IDLE;
          w_cursor_nxt = 3'd0;
        end else if (w_start) begin
          if (w_preset_nz) begin
            w_load_nxt     = 1'b1;
            w_count_up_nxt = mode;
            w_state_nxt    = ST_RUN;
            w_cursor_nxt   = 3'd0;
          end
        end else if (w_btn) begin
          w_cursor_nxt = (r_cursor == 3'(DIGITS - 1)) ? 3'd0 : r_cursor + 3'd1;
        end else if (w_inc) begin
          w_preset_nxt[{r_cursor, 2'b00} +: 4] = w_digit_inc;
        end else if (w_dec) begin
          w_preset_nxt[{r_cursor, 2'b00} +: 4] = w_digit_dec;
        end
      end
      ST_RUN: begin
        if (w_expire) begin
          w_state_nxt = ST_EXPIRED;
          w_acnt_nxt  = '0;
        end else begin
          w_count_en_nxt = tick;
          if (w_stop) w_state_nxt = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (w_stop) begin
          w_load_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_start) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_EXPIRED: begin
        if (w_stop || w_start || w_alarm_done) begin
          w_load_nxt  = 1'b1;
          w_acnt_nxt  = '0;
          w_state_nxt = ST_IDLE;
        end else if (tick) begin
          w_acnt_nxt = w_acnt_inc;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_ready_nxt = r_ready;
    if (w_state_nxt == ST_RUN || w_state_nxt == ST_EXPIRED)
      w_ready_nxt = 1'b0;
    else if (blink && (r_state == ST_IDLE || r_state == ST_SET || r_state == ST_PAUSE))
      w_ready_nxt = ~r_ready;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_preset   <= '0;
      r_cursor   <= 3'd0;
      r_load     <= 1'b0;
      r_load_d   <= 1'b0;
      r_count_en <= 1'b0;
      r_count_up <= 1'b1;
      r_ready    <= 1'b0;
      r_acnt     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_preset   <= w_preset_nxt;
      r_cursor   <= w_cursor_nxt;
      r_load     <= w_load_nxt;
      r_load_d   <= r_load;
      r_count_en <= w_count_en_nxt;
      r_count_up <= w_count_up_nxt;
      r_ready    <= w_ready_nxt;
      r_acnt     <= w_acnt_nxt;
    end
  end

  assign preset   = r_preset;
  assign load     = r_load;
  assign count_en = r_count_en;
  assign count_up = r_count_up;
  assign cursor   = r_cursor;
  assign state    = r_state;
  assign ready    = r_ready;
  assign alarm    = (r_state == ST_EXPIRED);

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_ctrl
// Description : Directed bench for stopwatch_ctrl with a digit-level model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_stopwatch_ctrl;

  localparam int c_AT = 4;
  localparam int M_IDLE = 0, M_SET = 1, M_RUN = 2, M_PAUSE = 3, M_EXP = 4;

  logic clk = 1'b0;
  logic reset, mode, start, stop, enc_btn, enc_inc, enc_dec, tick, blink, at_zero;
  logic [31:0] preset;
  logic        load, count_en, count_up, ready, alarm;
  logic [2:0]  cursor, state;

  stopwatch_ctrl #(.DIGITS(8), .MIN_TENS_DIGIT(5), .ALARM_TICKS(c_AT)) dut (
    .clk(clk), .reset(reset), .mode(mode), .start(start), .stop(stop),
    .enc_btn(enc_btn), .enc_inc(enc_inc), .enc_dec(enc_dec), .tick(tick),
    .blink(blink), .at_zero(at_zero), .preset(preset), .load(load),
    .count_en(count_en), .count_up(count_up), .cursor(cursor), .state(state),
    .ready(ready), .alarm(alarm)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: digits as integers, one step per clock using the sampled inputs
  int m_state, m_cursor, m_acnt, m_age;
  int m_dig[8];
  bit m_load, m_cen, m_up, m_ready;

  function automatic logic [31:0] m_preset();
    logic [31:0] v = 0;
    for (int i = 0; i < 8; i++) v = v | (32'(m_dig[i]) << (4 * i));
    return v;
  endfunction

  always @(posedge clk) begin
    int p, lim, ns;
    bit nl, nc;
    if (!reset) begin
      m_state = M_IDLE; m_cursor = 0; m_acnt = 0; m_age = 100;
      for (int i = 0; i < 8; i++) m_dig[i] = 0;
      m_load = 0; m_cen = 0; m_up = 1; m_ready = 0;
    end else begin
      p = stop ? 1 : start ? 2 : enc_btn ? 3 : enc_inc ? 4 : enc_dec ? 5 : 0;
      ns = m_state; nl = 0; nc = 0;
      lim = (m_cursor == 5) ? 5 : 9;
      case (m_state)
        M_IDLE: begin
          if (mode) for (int i = 0; i < 8; i++) m_dig[i] = 0;
          if (p == 2 && (mode || m_preset() != 0)) begin nl = 1; m_up = mode; ns = M_RUN; end
          else if (p == 3 && !mode) begin ns = M_SET; m_cursor = 0; end
        end
        M_SET: begin
          if (mode) begin
            ns = M_IDLE; m_cursor = 0;
            for (int i = 0; i < 8; i++) m_dig[i] = 0;
          end else if (p == 1) begin ns = M_IDLE; m_cursor = 0; end
          else if (p == 2) begin
            if (m_preset() != 0) begin nl = 1; m_up = 0; ns = M_RUN; m_cursor = 0; end
          end
          else if (p == 3) m_cursor = (m_cursor + 1) % 8;
          else if (p == 4) m_dig[m_cursor] = (m_dig[m_cursor] + 1) % (lim + 1);
          else if (p == 5) m_dig[m_cursor] = (m_dig[m_cursor] + lim) % (lim + 1);
        end
        M_RUN: begin
          if (!m_up && at_zero && m_age >= 2) begin ns = M_EXP; m_acnt = 0; end
          else begin nc = tick; if (p == 1) ns = M_PAUSE; end
        end
        M_PAUSE: begin
          if (p == 1) begin nl = 1; ns = M_IDLE; end
          else if (p == 2) ns = M_RUN;
        end
        default: begin
          if (p == 1 || p == 2 || (tick && m_acnt + 1 == c_AT)) begin
            nl = 1; m_acnt = 0; ns = M_IDLE;
          end else if (tick) m_acnt++;
        end
      endcase
      if (ns == M_RUN || ns == M_EXP) m_ready = 0;
      else if (blink && m_state != M_RUN && m_state != M_EXP) m_ready = !m_ready;
      m_state = ns; m_load = nl; m_cen = nc;
      if (nl) m_age = 0; else if (m_age < 100) m_age++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state",    32'(state),    32'(m_state));
      chk("preset",   preset,        m_preset());
      chk("cursor",   32'(cursor),   32'(m_cursor));
      chk("load",     32'(load),     32'(m_load));
      chk("count_en", 32'(count_en), 32'(m_cen));
      chk("count_up", 32'(count_up), 32'(m_up));
      chk("ready",    32'(ready),    32'(m_ready));
      chk("alarm",    32'(alarm),    32'(m_state == M_EXP));
    end
  end

  // 1 stop, 2 start, 3 enc_btn, 4 enc_inc, 5 enc_dec, 6 tick, 7 blink
  task automatic pulse(input int which);
    case (which)
      1: stop = 1;    2: start = 1;   3: enc_btn = 1; 4: enc_inc = 1;
      5: enc_dec = 1; 6: tick = 1;    7: blink = 1;
      default: ;
    endcase
    @(negedge clk);
    stop = 0; start = 0; enc_btn = 0; enc_inc = 0; enc_dec = 0; tick = 0; blink = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 0; mode = 0; start = 1; stop = 0; enc_btn = 0; enc_inc = 0;
    enc_dec = 0; tick = 0; blink = 0; at_zero = 0;
    cyc(3);
    chk_en = 1;
    chk("rst_state", 32'(state), 0);    chk("rst_preset", preset, 0);
    chk("rst_load", 32'(load), 0);      chk("rst_count_en", 32'(count_en), 0);
    chk("rst_alarm", 32'(alarm), 0);    chk("rst_ready", 32'(ready), 0);
    start = 0; reset = 1;
    cyc(1);

    // Preset editing
    pulse(3); chk("set_state", 32'(state), 1); chk("set_cursor", 32'(cursor), 0);
    repeat (3) pulse(4); chk("inc3", preset, 32'h0000_0003);
    repeat (4) pulse(5); chk("dec_wrap", preset, 32'h0000_0009);
    repeat (5) pulse(3); chk("cursor5", 32'(cursor), 5);
    repeat (5) pulse(4); chk("d5_at5", preset, 32'h0050_0009);
    pulse(4); chk("d5_wrap", preset, 32'h0000_0009);
    pulse(5); chk("d5_dec_wrap", preset, 32'h0050_0009);
    pulse(4);
    pulse(1); chk("set_stop", 32'(state), 0); chk("keep_preset", preset, 32'h9);

    // Countdown from 2, with at_zero held over the load window
    pulse(3); repeat (3) pulse(4); chk("preset2", preset, 32'h2);
    pulse(2); chk("run_load", 32'(load), 1); chk("run_state", 32'(state), 2);
    at_zero = 1; cyc(2); at_zero = 0;
    chk("guard_state", 32'(state), 2);
    for (int i = 0; i < 3; i++) begin
      pulse(6); chk("cen_hi", 32'(count_en), 1);
      cyc(1);   chk("cen_lo", 32'(count_en), 0);
      cyc(8);
    end
    at_zero = 1; tick = 1; cyc(1); at_zero = 0; tick = 0;
    chk("exp_state", 32'(state), 4); chk("exp_alarm", 32'(alarm), 1);
    chk("exp_cen", 32'(count_en), 0);

    // Alarm timeout, then abort by stop
    for (int i = 0; i < 3; i++) begin pulse(6); cyc(2); end
    chk("alarm_hold", 32'(state), 4);
    pulse(6); chk("to_state", 32'(state), 0); chk("to_load", 32'(load), 1);
    chk("to_alarm", 32'(alarm), 0);
    pulse(2); cyc(3);
    at_zero = 1; cyc(1); at_zero = 0; chk("exp2", 32'(state), 4);
    pulse(6); pulse(6);
    pulse(1); chk("stop_state", 32'(state), 0); chk("stop_load", 32'(load), 1);
    chk("stop_alarm", 32'(alarm), 0);
    pulse(7); chk("blink1", 32'(ready), 1);
    pulse(7); chk("blink0", 32'(ready), 0);

    // Count-up with pause/resume and mode change mid-run
    mode = 1; cyc(1); chk("up_preset", preset, 0);
    pulse(2); chk("up_load", 32'(load), 1); chk("up_dir", 32'(count_up), 1);
    cyc(3);
    pulse(6); chk("up_cen", 32'(count_en), 1);
    pulse(1); chk("pause", 32'(state), 3);
    cyc(1); pulse(6); chk("pause_cen", 32'(count_en), 0);
    pulse(7); chk("pause_blink", 32'(ready), 1);
    pulse(2); chk("resume", 32'(state), 2); chk("resume_noload", 32'(load), 0);
    mode = 0; cyc(2); chk("mode_mid_run", 32'(count_up), 1);
    pulse(6); chk("up_cen2", 32'(count_en), 1);
    pulse(1); pulse(1); chk("reset_load", 32'(load), 1); chk("reset_idle", 32'(state), 0);

    // Guards and priority
    pulse(2); chk("zero_start", 32'(state), 0); chk("zero_noload", 32'(load), 0);
    mode = 1; cyc(1); pulse(2); cyc(2);
    start = 1; stop = 1; cyc(1); start = 0; stop = 0;
    chk("prio_pause", 32'(state), 3);
    pulse(1); mode = 0; cyc(1);
    pulse(3); pulse(4); chk("edit1", preset, 32'h1);
    mode = 1; cyc(1); chk("mode_exit", 32'(state), 0); chk("mode_clr", preset, 0);
    mode = 0; cyc(5);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
